// File: rtl/qpsk_frame_pkg.sv
// rtl/qpsk_frame_pkg.sv - shared 40-bit QPSK frame format: fields, defaults, checksum, parser states
package qpsk_frame_pkg;

    localparam int FRAME_W = 40;

    localparam logic [6:0] QPSK_SYNC      = 7'h55;
    localparam logic [7:0] QPSK_CSUM_SEED = 8'h5A;

    // Field bit positions within the 40-bit frame
    localparam int SYNC_HI = 39;
    localparam int SYNC_LO = 33;
    localparam int SEQ_BIT = 32;
    localparam int B2_LO   = 24;
    localparam int B1_LO   = 16;
    localparam int B0_LO   = 8;
    localparam int CSUM_LO = 0;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } deframe_state_t;

    // Checksum over the three payload bytes; the framer and deframer must agree on the seed
    function automatic logic [7:0] qpsk_csum(
        input logic [7:0] b2,
        input logic [7:0] b1,
        input logic [7:0] b0,
        input logic [7:0] seed = QPSK_CSUM_SEED
    );
        return b2 ^ b1 ^ b0 ^ seed;
    endfunction

endpackage

// File: rtl/qpsk_stable_det.sv
// rtl/qpsk_stable_det.sv - stability filter that strobes each new settled frame word once
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   frame_in    - unstrobed demodulated word, may glitch while updating
//   eval_stb    - one-cycle strobe: eval_word has settled and is new
//   eval_word   - the settled candidate word
module qpsk_stable_det #(
    parameter int STABLE_CYCLES = 4,
    parameter int W             = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] frame_in,
    output logic         eval_stb,
    output logic [W-1:0] eval_word
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    logic [W-1:0]     cand;
    logic [W-1:0]     last_word;
    logic [CNT_W-1:0] cnt;
    logic             evaluated;
    logic             same;

    assign same = (frame_in == cand);

    // The edge that reloads the candidate counts as its first stable cycle, so
    // a value first sampled at edge t strobes at edge t+STABLE_CYCLES.
    assign eval_stb  = same && (cnt == CNT_LAST) && (!evaluated || (cand != last_word));
    assign eval_word = cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand      <= '0;
            last_word <= '0;
            cnt       <= '0;
            evaluated <= 1'b0;
        end else begin
            if (!same) begin
                cand <= frame_in;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                // Saturate so a persisting value never strobes again
                cnt <= cnt + CNT_W'(1);
            end
            if (eval_stb) begin
                last_word <= cand;
                evaluated <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/qpsk_deframe.sv
// rtl/qpsk_deframe.sv - QPSK receive frame parser: HUNT/LOCK checks and payload byte stream
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   frame_in    - 40-bit demodulated word (sync, seq, b2, b1, b0, csum)
//   byte_out    - payload byte, order b2, b1, b0
//   byte_valid  - byte_out valid; held until byte_ready
//   byte_ready  - sink accepts byte when byte_valid && byte_ready
//   locked      - high while in LOCK
//   frame_err   - one-cycle pulse per evaluated frame that fails a check
//   overflow    - one-cycle pulse when a good frame is dropped (buffer busy)
//   err_cnt     - saturating count of frame_err pulses
module qpsk_deframe
    import qpsk_frame_pkg::*;
#(
    parameter int         STABLE_CYCLES = 4,
    parameter int         MISS_MAX      = 3,
    parameter logic [6:0] SYNC          = QPSK_SYNC,
    parameter logic [7:0] CSUM_SEED     = QPSK_CSUM_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame_in,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               locked,
    output logic               frame_err,
    output logic               overflow,
    output logic [15:0]        err_cnt
);

    localparam int MISS_W = $clog2(MISS_MAX + 1);

    logic               eval_stb;
    logic [FRAME_W-1:0] eval_word;

    qpsk_stable_det #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .W             (FRAME_W)
    ) u_stable_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_in  (frame_in),
        .eval_stb  (eval_stb),
        .eval_word (eval_word)
    );

    deframe_state_t    state;
    logic              last_seq;
    logic [MISS_W-1:0] miss_cnt;
    logic [MISS_W-1:0] miss_inc;
    logic [23:0]       pay_buf;
    logic [1:0]        rem;

    logic [7:0] f_b2, f_b1, f_b0, f_csum;
    logic       sync_ok, csum_ok, seq_ok;
    logic       good, bad, load, drop;

    assign f_b2   = eval_word[B2_LO +: 8];
    assign f_b1   = eval_word[B1_LO +: 8];
    assign f_b0   = eval_word[B0_LO +: 8];
    assign f_csum = eval_word[CSUM_LO +: 8];

    assign sync_ok = (eval_word[SYNC_HI:SYNC_LO] == SYNC);
    assign csum_ok = (f_csum == qpsk_csum(f_b2, f_b1, f_b0, CSUM_SEED));
    assign seq_ok  = (eval_word[SEQ_BIT] != last_seq);

    // The seq toggle only means something once we know the previous frame
    assign good = eval_stb && sync_ok && csum_ok && ((state == HUNT) || seq_ok);
    assign bad  = eval_stb && !good;
    assign load = good && (rem == 2'd0);
    assign drop = good && (rem != 2'd0);

    assign miss_inc = miss_cnt + MISS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            locked    <= 1'b0;
            last_seq  <= 1'b0;
            miss_cnt  <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= bad;
            overflow  <= drop;
            if (bad && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (good) begin
                // A dropped (overflowed) frame still advances lock and seq
                state    <= LOCK;
                locked   <= 1'b1;
                last_seq <= eval_word[SEQ_BIT];
                miss_cnt <= '0;
            end else if (bad && (state == LOCK)) begin
                if (miss_inc == MISS_W'(MISS_MAX)) begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    miss_cnt <= '0;
                end else begin
                    miss_cnt <= miss_inc;
                end
            end
        end
    end

    // rem counts bytes not yet accepted by the sink, including the one on byte_out
    function automatic logic [7:0] pick(input logic [23:0] pb, input logic [1:0] r);
        case (r)
            2'd3:    return pb[23:16];
            2'd2:    return pb[15:8];
            default: return pb[7:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_buf    <= '0;
            rem        <= 2'd0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else if (load) begin
            pay_buf <= {f_b2, f_b1, f_b0};
            rem     <= 2'd3;
        end else if (rem != 2'd0) begin
            if (!byte_valid) begin
                byte_valid <= 1'b1;
                byte_out   <= pick(pay_buf, rem);
            end else if (byte_ready) begin
                rem <= rem - 2'd1;
                if (rem == 2'd1) begin
                    byte_valid <= 1'b0;
                end else begin
                    byte_out <= pick(pay_buf, rem - 2'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_qpsk_deframe.sv
// tb/tb_qpsk_deframe.sv - directed self-checking bench for qpsk_deframe
module tb_qpsk_deframe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] frame_in;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        locked;
    logic        frame_err;
    logic        overflow;
    logic [15:0] err_cnt;

    int n_vec = 0;
    int n_mis = 0;
    int n_err_pulse = 0;
    int n_ovf_pulse = 0;
    logic [7:0] got_q[$];

    // sync 0x55 in [39:33]; csum = b2^b1^b0^5A
    localparam logic [39:0] F1     = 40'hAA_112233_5A; // seq 0, 11^22^33^5A = 5A
    localparam logic [39:0] F2     = 40'hAB_445566_2D; // seq 1, 44^55^66^5A = 2D
    localparam logic [39:0] BAD1   = 40'hAB_445566_D2; // csum inverted
    localparam logic [39:0] BAD2   = 40'hAA_112233_A5; // csum inverted
    localparam logic [39:0] GLITCH = 40'h00_000000_00;

    always #5 clk = ~clk;

    qpsk_deframe #(
        .STABLE_CYCLES (4),
        .MISS_MAX      (3),
        .SYNC          (7'h55),
        .CSUM_SEED     (8'h5A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_in   (frame_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .locked     (locked),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_cnt    (err_cnt)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (byte_valid && byte_ready) got_q.push_back(byte_out);
            if (frame_err) n_err_pulse++;
            if (overflow) n_ovf_pulse++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [39:0] w, input int n);
        frame_in = w;
        tick(n);
    endtask

    // exp holds n bytes, first-delivered in the most significant position
    task automatic expect_bytes(input string tag, input logic [31:0] exp, input int n);
        logic [7:0] g;
        check_val({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check_val({tag, "_byte"}, {24'd0, g}, {24'd0, exp[8*(n-1-i) +: 8]});
        end
        got_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_ready = 1'b1;
        frame_in   = '0;
        tick(3);
        check_val("rst_locked", locked, 0);
        check_val("rst_valid", byte_valid, 0);
        check_val("rst_byte", byte_out, 0);
        check_val("rst_ferr", frame_err, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_errcnt", err_cnt, 0);

        // first frame: lock at t+4, bytes on t+5..t+7
        rst_n    = 1'b1;
        frame_in = F1;
        tick(4);
        check_val("f1_unlocked_t3", locked, 0);
        tick(1);
        check_val("f1_locked_t4", locked, 1);
        check_val("f1_valid_t4", byte_valid, 0);
        check_val("f1_ferr_t4", frame_err, 0);
        tick(1);
        check_val("f1_valid_t5", byte_valid, 1);
        check_val("f1_b2", byte_out, 8'h11);
        tick(1);
        check_val("f1_b1", byte_out, 8'h22);
        tick(1);
        check_val("f1_b0", byte_out, 8'h33);
        tick(1);
        check_val("f1_valid_t8", byte_valid, 0);
        tick(2);
        expect_bytes("f1", 32'h112233, 3);

        hold(F2, 10);
        expect_bytes("f2", 32'h445566, 3);
        hold(F1, 10);
        expect_bytes("f1_again", 32'h112233, 3);
        check_val("f1_again_locked", locked, 1);

        // short glitch then back to the already-evaluated word
        hold(GLITCH, 2);
        hold(F1, 8);
        expect_bytes("glitch", 32'h0, 0);
        check_val("glitch_ferr", n_err_pulse, 0);
        check_val("glitch_errcnt", err_cnt, 0);

        // three bad checksums drop lock on the third
        hold(BAD1, 6);
        check_val("bad1_locked", locked, 1);
        check_val("bad1_errcnt", err_cnt, 1);
        hold(BAD2, 6);
        check_val("bad2_locked", locked, 1);
        check_val("bad2_errcnt", err_cnt, 2);
        hold(BAD1, 6);
        check_val("bad3_locked", locked, 0);
        check_val("bad3_errcnt", err_cnt, 3);
        check_val("bad_pulses", n_err_pulse, 3);
        expect_bytes("bad", 32'h0, 0);
        hold(F2, 10);
        check_val("relock", locked, 1);
        expect_bytes("relock", 32'h445566, 3);

        // sink stalled: second good frame overflows
        byte_ready = 1'b0;
        hold(F1, 6);
        check_val("stall_valid", byte_valid, 1);
        check_val("stall_b2", byte_out, 8'h11);
        hold(F2, 6);
        check_val("ovf_pulses", n_ovf_pulse, 1);
        check_val("ovf_valid", byte_valid, 1);
        check_val("ovf_b2_held", byte_out, 8'h11);
        check_val("ovf_locked", locked, 1);
        byte_ready = 1'b1;
        tick(6);
        expect_bytes("ovf", 32'h112233, 3);
        check_val("ovf_pulses_end", n_ovf_pulse, 1);

        // reset after b2 accepted
        frame_in = F1;
        tick(6);
        check_val("mid_valid", byte_valid, 1);
        check_val("mid_b2", byte_out, 8'h11);
        tick(1);
        check_val("mid_b1", byte_out, 8'h22);
        rst_n = 1'b0;
        #1;
        check_val("rstmid_valid", byte_valid, 0);
        check_val("rstmid_locked", locked, 0);
        check_val("rstmid_errcnt", err_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check_val("post_rst_unlocked", locked, 0);
        tick(1);
        check_val("post_rst_locked", locked, 1);
        tick(5);
        expect_bytes("post_rst", 32'h11112233, 4);
        check_val("post_rst_errcnt", err_cnt, 0);
        check_val("total_err_pulses", n_err_pulse, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
